// File: rtl/mem_lsu.sv
// Multi-cycle MIPS load/store unit: req/ack data-bus handshake with pipeline stall,
// address-error, bus-error/timeout reporting and flush handling.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              whilo_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              whilo_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              stall_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              excp_adel_o,
  output logic              excp_ades_o,
  output logic              excp_bus_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWL = 8'b1110_0010;
  localparam logic [7:0] OP_LWR = 8'b1110_0110;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SWR = 8'b1110_1110;
  localparam logic [31:0] TO    = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  function automatic logic is_load(input logic [7:0] op);
    is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) ||
              (op == OP_LW) || (op == OP_LWL) || (op == OP_LWR);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
               (op == OP_SWL) || (op == OP_SWR);
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = off[0];
      OP_LW, OP_SW:         misaligned = |off;
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // Lane 0 is the most significant byte (big-endian), hence sel bit 3 for offset 0
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
    case (op)
      OP_SB, OP_LB, OP_LBU: lane_sel = 4'b1000 >> off;
      OP_SH, OP_LH, OP_LHU: lane_sel = off[1] ? 4'b0011 : 4'b1100;
      OP_SWL:               lane_sel = 4'b1111 >> off;
      OP_SWR:               lane_sel = 4'b1111 << (2'd3 - off);
      default:              lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [7:0] op, input logic [1:0] off,
                                            input logic [31:0] r2);
    case (op)
      OP_SB:   lane_data = {4{r2[7:0]}};
      OP_SH:   lane_data = {2{r2[15:0]}};
      OP_SWL:  lane_data = r2 >> {off, 3'b000};
      OP_SWR:  lane_data = r2 << {(2'd3 - off), 3'b000};
      default: lane_data = r2;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [7:0] op, input logic [1:0] off,
                                              input logic [31:0] rd, input logic [31:0] r2);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {(2'd3 - off), 3'b000});
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   load_result = {{24{b[7]}}, b};
      OP_LBU:  load_result = {24'd0, b};
      OP_LH:   load_result = {{16{h[15]}}, h};
      OP_LHU:  load_result = {16'd0, h};
      OP_LWL:  load_result = (rd << {off, 3'b000}) | (r2 & ~(32'hFFFF_FFFF << {off, 3'b000}));
      OP_LWR:  load_result = (rd >> {(2'd3 - off), 3'b000}) |
                             (r2 & ~(32'hFFFF_FFFF >> {(2'd3 - off), 3'b000}));
      default: load_result = rd;
    endcase
  endfunction

  state_t              state_r, state_s;
  logic [31:0]         cnt_r;
  logic [7:0]          op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         reg2_r, wdata_r, hi_r, lo_r, res_r;
  logic [4:0]          wd_r;
  logic                wreg_r, whilo_r, flushed_r, err_r;
  logic                mem_op_s, mis_s, go_s, timeout_s, done_s, err_s, squash_s;

  assign mem_op_s  = valid_i && (is_load(aluop_i) || is_store(aluop_i));
  assign mis_s     = mem_op_s && misaligned(aluop_i, mem_addr_i[1:0]);
  assign go_s      = mem_op_s && !mis_s && !flush_i;
  assign timeout_s = (TO != 32'd0) && (cnt_r == TO);
  assign err_s     = bus_err_i || timeout_s;
  assign done_s    = bus_ack_i || err_s;
  assign squash_s  = flushed_r || flush_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = go_s ? REQ : IDLE;
      REQ:     if (done_s) state_s = squash_s ? IDLE : RESP;
               else        state_s = REQ;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Bus outputs, latched operation fields, timeout counter and captured result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_o <= 1'b0;  bus_we_o <= 1'b0;  bus_sel_o <= 4'd0;
      bus_addr_o <= '0;   bus_wdata_o <= 32'd0;
      cnt_r <= 32'd0;     op_r <= 8'd0;      addr_r <= '0;
      reg2_r <= 32'd0;    wdata_r <= 32'd0;  hi_r <= 32'd0;  lo_r <= 32'd0;
      res_r <= 32'd0;     wd_r <= 5'd0;      wreg_r <= 1'b0; whilo_r <= 1'b0;
      flushed_r <= 1'b0;  err_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (go_s) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= is_store(aluop_i);
        bus_sel_o   <= lane_sel(aluop_i, mem_addr_i[1:0]);
        bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        bus_wdata_o <= lane_data(aluop_i, mem_addr_i[1:0], reg2_i);
        cnt_r <= 32'd0;     op_r <= aluop_i;   addr_r <= mem_addr_i;
        reg2_r <= reg2_i;   wdata_r <= wdata_i; hi_r <= hi_i;  lo_r <= lo_i;
        wd_r <= wd_i;       wreg_r <= wreg_i;  whilo_r <= whilo_i;
        flushed_r <= 1'b0;  err_r <= 1'b0;
      end else begin
        bus_req_o <= 1'b0;
      end
    end else if (state_r == REQ) begin
      cnt_r <= cnt_r + 32'd1;
      if (flush_i) flushed_r <= 1'b1;
      else         flushed_r <= flushed_r;
      if (done_s) begin
        bus_req_o <= 1'b0;
        err_r     <= err_s;
        res_r     <= is_load(op_r) ? load_result(op_r, addr_r[1:0], bus_rdata_i, reg2_r)
                                   : wdata_r;
      end else begin
        bus_req_o <= 1'b1;
      end
    end else begin
      bus_req_o <= 1'b0;
    end
  end

  // Write-back, stall and exception outputs
  always_comb begin
    wd_o = wd_i;  wreg_o = wreg_i;  wdata_o = wdata_i;
    whilo_o = whilo_i;  hi_o = hi_i;  lo_o = lo_i;
    stall_req_o = 1'b0;
    excp_adel_o = 1'b0;  excp_ades_o = 1'b0;  excp_bus_o = 1'b0;
    badvaddr_o  = '0;
    case (state_r)
      IDLE: begin
        if (flush_i) begin
          wreg_o = 1'b0;  whilo_o = 1'b0;
        end else if (mis_s) begin
          excp_adel_o = is_load(aluop_i);
          excp_ades_o = is_store(aluop_i);
          badvaddr_o  = mem_addr_i;
          wreg_o      = 1'b0;
        end else if (go_s) begin
          stall_req_o = 1'b1;  wreg_o = 1'b0;  whilo_o = 1'b0;
        end else begin
          stall_req_o = 1'b0;
        end
      end
      REQ: begin
        wreg_o = 1'b0;  whilo_o = 1'b0;
        stall_req_o = !(done_s && squash_s);
      end
      RESP: begin
        wd_o = wd_r;  wdata_o = res_r;  hi_o = hi_r;  lo_o = lo_r;
        wreg_o  = wreg_r && !err_r;
        whilo_o = whilo_r && !err_r;
        excp_bus_o = err_r;
        badvaddr_o = err_r ? addr_r : '0;
      end
      default: stall_req_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences for reset/flush,
// and randomized operations checked against a byte-lane reference model.
module tb_mem_lsu;
  localparam int TMO = 4;
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3,
                         LWL = 8'hE2, LWR = 8'hE6, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB,
                         SWL = 8'hEA, SWR = 8'hEE, NOP = 8'h21;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_i = 1'b0, flush_i = 1'b0, wreg_i = 1'b1, whilo_i = 1'b0;
  logic [7:0] aluop_i = 8'd0;
  logic [31:0] mem_addr_i = 32'd0, reg2_i = 32'd0, wdata_i = 32'h1111_2222;
  logic [31:0] hi_i = 32'd0, lo_i = 32'd0, bus_rdata_i = 32'd0;
  logic [4:0] wd_i = 5'd7;
  logic bus_ack_i = 1'b0, bus_err_i = 1'b0;
  logic [4:0] wd_o;
  logic wreg_o, whilo_o, stall_req_o, bus_req_o, bus_we_o;
  logic [31:0] wdata_o, hi_o, lo_o, bus_addr_o, bus_wdata_o, badvaddr_o;
  logic [3:0] bus_sel_o;
  logic excp_adel_o, excp_ades_o, excp_bus_o;

  int n_checks = 0, n_fail = 0;

  mem_lsu #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o),
    .lo_o(lo_o), .stall_req_o(stall_req_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o), .excp_bus_o(excp_bus_o),
    .badvaddr_o(badvaddr_o));

  always #5 clk = ~clk;

  // mode: 0 ack, 1 bus error, 2 silent bus; fl: REQ-cycle index carrying flush_i (-1 none)
  typedef struct {
    logic [7:0] op; logic [31:0] addr, reg2, rdata; int waits, mode, fl;
    logic [3:0] sel; logic [31:0] bw, wd; logic wreg; int stalls; logic [2:0] exc;
    logic chk_wd;
  } vec_t;

  typedef struct {
    int stalls; logic saw_req, unstable, timed_out;
    logic [3:0] sel; logic [31:0] bw, baddr; logic we;
    logic [31:0] wd, badv; logic wreg; logic [2:0] exc;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_is_store(input logic [7:0] op);
    return op == SB || op == SH || op == SW || op == SWL || op == SWR;
  endfunction
  function automatic logic m_is_load(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW || op == LWL || op == LWR;
  endfunction

  // Reference model: which byte lanes are touched and what each store lane carries
  function automatic void m_lanes(input logic [7:0] op, input int k, input logic [31:0] reg2,
                                  output logic [3:0] sel, output logic [31:0] bw);
    logic [7:0] r[4];
    for (int i = 0; i < 4; i++) r[i] = reg2[31-8*i -: 8];
    sel = 4'd0; bw = 32'd0;
    for (int l = 0; l < 4; l++) begin
      logic on; logic [7:0] b;
      on = 1'b0; b = 8'd0;
      if (op == SB || op == LB || op == LBU) begin on = (l == k); b = r[3]; end
      else if (op == SH || op == LH || op == LHU) begin
        on = (l == k) || (l == k + 1); b = (l == k) ? r[2] : r[3];
      end
      else if (op == SWL) begin on = (l >= k); if (on) b = r[l-k]; end
      else if (op == SWR) begin on = (l <= k); if (on) b = r[3-k+l]; end
      else begin on = 1'b1; b = r[l]; end
      sel[3-l] = on;
      bw[31-8*l -: 8] = on ? b : 8'd0;
    end
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input int k,
                                         input logic [31:0] rd, input logic [31:0] reg2);
    logic [7:0] d[4], r[4], q[4];
    for (int i = 0; i < 4; i++) begin d[i] = rd[31-8*i -: 8]; r[i] = reg2[31-8*i -: 8]; end
    case (op)
      LB:  return {{24{d[k][7]}}, d[k]};
      LBU: return {24'd0, d[k]};
      LH:  return {{16{d[k][7]}}, d[k], d[k+1]};
      LHU: return {16'd0, d[k], d[k+1]};
      LWL: for (int i = 0; i < 4; i++) if (i <= 3 - k) q[i] = d[k+i]; else q[i] = r[i];
      LWR: for (int i = 0; i < 4; i++) if (i >= 3 - k) q[i] = d[i-3+k]; else q[i] = r[i];
      default: return rd;
    endcase
    return {q[0], q[1], q[2], q[3]};
  endfunction

  function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr, reg2, rdata,
                                 input int waits, mode, fl);
    vec_t v; int k; logic mem, mis;
    k = int'(addr[1:0]);
    mem = m_is_load(op) || m_is_store(op);
    mis = ((op == LH || op == LHU || op == SH) && addr[0]) || ((op == LW || op == SW) && k != 0);
    v = '{op, addr, reg2, rdata, waits, mode, fl, 4'd0, 32'd0, 32'h1111_2222, 1'b0, 0, 3'd0, 1'b0};
    m_lanes(op, k, reg2, v.sel, v.bw);
    if (!mem) begin v.wreg = 1'b1; v.chk_wd = 1'b1; end
    else if (mis) v.exc = m_is_load(op) ? 3'b100 : 3'b010;
    else if (fl >= 0) v.stalls = waits + 1;
    else if (mode == 2) begin v.stalls = TMO + 2; v.exc = 3'b001; end
    else if (mode == 1) begin v.stalls = waits + 2; v.exc = 3'b001; end
    else begin
      v.stalls = waits + 2; v.chk_wd = 1'b1; v.wreg = m_is_load(op);
      if (m_is_load(op)) v.wd = m_load(op, k, rdata, reg2);
    end
    return v;
  endfunction

  // Drives one instruction from a cycle start (posedge+1) until the pipeline is released
  task automatic run_op(input vec_t v, output obs_t o);
    int req_cnt; logic done, req_s;
    o = '{0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0};
    valid_i = 1'b1; aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
    wreg_i = !m_is_store(v.op); wdata_i = 32'h1111_2222;
    req_cnt = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_ack_i = 1'b0; bus_err_i = 1'b0; flush_i = 1'b0; bus_rdata_i = 32'hDEAD_BEEF;
      if (bus_req_o) begin
        if (req_cnt == v.fl) flush_i = 1'b1;
        if (req_cnt == v.waits && v.mode == 0) begin bus_ack_i = 1'b1; bus_rdata_i = v.rdata; end
        if (req_cnt == v.waits && v.mode == 1) bus_err_i = 1'b1;
      end
      #4;
      req_s = bus_req_o;
      if (req_s) begin
        if (!o.saw_req) begin
          o.sel = bus_sel_o; o.bw = bus_wdata_o; o.baddr = bus_addr_o; o.we = bus_we_o;
        end else if (o.sel !== bus_sel_o || o.bw !== bus_wdata_o || o.baddr !== bus_addr_o ||
                     o.we !== bus_we_o) o.unstable = 1'b1;
        o.saw_req = 1'b1;
      end
      if (stall_req_o) o.stalls++;
      else begin
        done = 1'b1; o.wd = wdata_o; o.wreg = wreg_o; o.badv = badvaddr_o;
        o.exc = {excp_adel_o, excp_ades_o, excp_bus_o};
      end
      @(posedge clk); #1;
      if (req_s) req_cnt++;
    end
    o.timed_out = !done;
    valid_i = 1'b0; wreg_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    logic [31:0] m;
    m = {{8{v.sel[3]}}, {8{v.sel[2]}}, {8{v.sel[1]}}, {8{v.sel[0]}}};
    chk({tag, ".done"}, {31'd0, o.timed_out}, 32'd0);
    chk({tag, ".stalls"}, o.stalls, v.stalls);
    chk({tag, ".wreg"}, {31'd0, o.wreg}, {31'd0, v.wreg});
    chk({tag, ".exc"}, {29'd0, o.exc}, {29'd0, v.exc});
    if (v.exc != 3'd0) chk({tag, ".badvaddr"}, o.badv, v.addr);
    chk({tag, ".bus_used"}, {31'd0, o.saw_req}, {31'd0, v.stalls > 0});
    if (o.saw_req && v.stalls > 0) begin
      chk({tag, ".sel"}, {28'd0, o.sel}, {28'd0, v.sel});
      chk({tag, ".addr"}, o.baddr, v.addr & 32'hFFFF_FFFC);
      chk({tag, ".we"}, {31'd0, o.we}, {31'd0, m_is_store(v.op)});
      chk({tag, ".stable"}, {31'd0, o.unstable}, 32'd0);
      if (m_is_store(v.op)) chk({tag, ".bwdata"}, o.bw & m, v.bw & m);
    end
    if (v.chk_wd) chk({tag, ".wdata"}, o.wd, v.wd);
    // The cycle after release must be quiet: no late RESP or exception
    #3;
    chk({tag, ".after_exc"}, {31'd0, excp_bus_o}, 32'd0);
    chk({tag, ".after_wreg"}, {31'd0, wreg_o}, 32'd0);
    chk({tag, ".after_stall"}, {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[14];
  vec_t v;
  obs_t o;

  initial begin
    tbl[0]  = '{LB,  32'h1001, 32'h0,        32'h1280FF34, 0, 0, -1, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b1, 2, 3'b000, 1'b1};
    tbl[1]  = '{SWR, 32'h2002, 32'hAABBCCDD, 32'h0,        3, 0, -1, 4'b1110, 32'hBBCCDD00, 32'h11112222, 1'b0, 5, 3'b000, 1'b1};
    tbl[2]  = '{LW,  32'h3006, 32'h0,        32'h0,        0, 0, -1, 4'b1111, 32'h0,        32'h0,        1'b0, 0, 3'b100, 1'b0};
    tbl[3]  = '{LW,  32'h4000, 32'h0,        32'h0,        0, 2, -1, 4'b1111, 32'h0,        32'h0,        1'b0, 6, 3'b001, 1'b0};
    tbl[4]  = '{LW,  32'h4004, 32'h0,        32'h0,        1, 1, -1, 4'b1111, 32'h0,        32'h0,        1'b0, 3, 3'b001, 1'b0};
    tbl[5]  = '{SH,  32'h5002, 32'h0000BEEF, 32'h0,        2, 0,  0, 4'b0011, 32'hBEEFBEEF, 32'h0,        1'b0, 3, 3'b000, 1'b0};
    tbl[6]  = '{SW,  32'h6001, 32'h0,        32'h0,        0, 0, -1, 4'b1111, 32'h0,        32'h0,        1'b0, 0, 3'b010, 1'b0};
    tbl[7]  = '{LWL, 32'h7001, 32'h11223344, 32'hAABBCCDD, 0, 0, -1, 4'b1111, 32'h0,        32'hBBCCDD44, 1'b1, 2, 3'b000, 1'b1};
    tbl[8]  = '{LWR, 32'h7001, 32'h11223344, 32'hAABBCCDD, 1, 0, -1, 4'b1111, 32'h0,        32'h1122AABB, 1'b1, 3, 3'b000, 1'b1};
    tbl[9]  = '{LHU, 32'h8002, 32'h0,        32'h1234F678, 0, 0, -1, 4'b0011, 32'h0,        32'h0000F678, 1'b1, 2, 3'b000, 1'b1};
    tbl[10] = '{LH,  32'h8000, 32'h0,        32'h8001ABCD, 2, 0, -1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b1, 4, 3'b000, 1'b1};
    tbl[11] = '{SB,  32'h9003, 32'h0000005A, 32'h0,        0, 0, -1, 4'b0001, 32'h5A5A5A5A, 32'h11112222, 1'b0, 2, 3'b000, 1'b1};
    tbl[12] = '{SWL, 32'h9001, 32'hAABBCCDD, 32'h0,        0, 0, -1, 4'b0111, 32'h00AABBCC, 32'h11112222, 1'b0, 2, 3'b000, 1'b1};
    tbl[13] = '{NOP, 32'h0123, 32'h0,        32'h0,        0, 0, -1, 4'b1111, 32'h0,        32'h11112222, 1'b1, 0, 3'b000, 1'b1};

    // Reset state: registered bus outputs cleared, comb outputs pass through
    #3;
    chk("rst.bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst.bus_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst.bus_sel", {28'd0, bus_sel_o}, 32'd0);
    chk("rst.bus_addr", bus_addr_o, 32'd0);
    chk("rst.bus_wdata", bus_wdata_o, 32'd0);
    chk("rst.stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst.wreg_pass", {31'd0, wreg_o}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b1; wreg_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i], o);
      check_vec($sformatf("vec%0d", i), tbl[i], o);
    end

    // Flush in IDLE: no request, write-back suppressed
    valid_i = 1'b1; aluop_i = LW; mem_addr_i = 32'hB000; wreg_i = 1'b1; whilo_i = 1'b1;
    flush_i = 1'b1; #4;
    chk("idle_flush.wreg", {31'd0, wreg_o}, 32'd0);
    chk("idle_flush.whilo", {31'd0, whilo_o}, 32'd0);
    chk("idle_flush.stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b0; wreg_i = 1'b0; whilo_i = 1'b0; #4;
    chk("idle_flush.no_req", {31'd0, bus_req_o}, 32'd0);
    @(posedge clk); #1;

    // Reset asserted mid-REQ drops the bus request asynchronously
    valid_i = 1'b1; aluop_i = LW; mem_addr_i = 32'hA000; wreg_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #2;
    chk("midrst.req_before", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst.req", {31'd0, bus_req_o}, 32'd0);
    chk("midrst.sel", {28'd0, bus_sel_o}, 32'd0);
    chk("midrst.stall", {31'd0, stall_req_o}, 32'd0);
    chk("midrst.exc", {31'd0, excp_bus_o}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; wreg_i = 1'b0;
    @(posedge clk); #1;
    v = model(LW, 32'hA004, 32'h0, 32'hCAFEF00D, 1, 0, -1);
    run_op(v, o);
    check_vec("after_rst", v, o);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ops[13];
      int w, md, fl, r;
      ops = '{LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR, NOP};
      w = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      md = (r < 10) ? 1 : (r < 15) ? 2 : 0;
      fl = (md != 2 && $urandom_range(0, 9) == 0) ? $urandom_range(0, w) : -1;
      v = model(ops[$urandom_range(0, 12)], $urandom, $urandom, $urandom, w, md, fl);
      run_op(v, o);
      check_vec($sformatf("rnd%0d", i), v, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
